// File: rtl/spi_resp_framer.sv
// -----------------------------------------------------------------------------
// spi_resp_framer
//
// Drains the SPI response FIFO and wraps each pending burst into a framed
// packet on a byte-wide valid/ready stream towards the host-link transmitter:
//
//   SYNC_BYTE, CHAN_ID, LEN, payload[LEN], CHECK
//
// LEN is min(fill level, MAX_LEN). A larger backlog is sent as several frames.
// CHECK covers CHAN_ID, LEN and the payload. SYNC is not included.
//
// Build option:
//   SPI_FRAMER_CRC8_EN  defined     -> CHECK is CRC-8 (poly 0x07, init 0x00,
//                                      MSB-first, no final XOR)
//                       not defined -> CHECK is the 8-bit sum mod 256
//   The state sequence and the timing are the same in both builds.
//
// Ports:
//   clk          in   clock
//   n_rst        in   asynchronous active-low reset
//   have_msg     in   response FIFO non-empty
//   len    [7:0] in   response FIFO fill level in bytes
//   out_data[7:0] in  FIFO read data, valid the cycle after rd_req
//   rd_req       out  FIFO read strobe, single-cycle pulses
//   tx_data[7:0] out  frame byte to the transmitter
//   tx_valid     out  tx_data valid
//   tx_ready     in   transmitter accepts the byte on tx_valid & tx_ready
//   busy         out  frame in progress
//   frames_sent[7:0] out  completed-frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module spi_resp_framer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       have_msg,
  input  logic [7:0] len,
  input  logic [7:0] out_data,
  output logic       rd_req,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHAN_ID   = 8'h00;
  localparam logic [7:0] MAX_LEN   = 8'd64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_ID    = 3'd2,
    ST_LEN   = 3'd3,
    ST_FETCH = 3'd4,
    ST_LOAD  = 3'd5,
    ST_DATA  = 3'd6,
    ST_CHK   = 3'd7
  } state_t;

  state_t     state_r;
  logic [7:0] cnt_r;   // payload bytes still to be read for this frame
  logic [7:0] chk_r;   // running check byte
  logic       hs_s;    // byte accepted by the transmitter this cycle

  // Fold one byte into the running check value.
  function automatic logic [7:0] fold_byte(input logic [7:0] acc, input logic [7:0] b);
`ifdef SPI_FRAMER_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
`else
    return acc + b;
`endif
  endfunction

  assign hs_s = tx_valid & tx_ready;

  // Framing FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      chk_r       <= 8'd0;
      rd_req      <= 1'b0;
      tx_data     <= 8'd0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rd_req   <= 1'b0;
          tx_valid <= 1'b0;
          // A zero fill level with have_msg set is a lagging count: wait.
          if (have_msg && (len != 8'd0)) begin
            cnt_r    <= (len > MAX_LEN) ? MAX_LEN : len;
            chk_r    <= 8'd0;
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state_r  <= ST_SYNC;
          end else begin
            busy     <= 1'b0;
          end
        end

        ST_SYNC: begin
          if (hs_s) begin
            tx_data <= CHAN_ID;
            state_r <= ST_ID;
          end
        end

        ST_ID: begin
          if (hs_s) begin
            chk_r   <= fold_byte(chk_r, CHAN_ID);
            tx_data <= cnt_r;
            state_r <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (hs_s) begin
            chk_r    <= fold_byte(chk_r, cnt_r);
            tx_valid <= 1'b0;
            rd_req   <= 1'b1;   // high for the whole FETCH cycle only
            state_r  <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          rd_req  <= 1'b0;
          state_r <= ST_LOAD;
        end

        ST_LOAD: begin
          // out_data now holds the byte requested in FETCH.
          tx_data  <= out_data;
          tx_valid <= 1'b1;
          chk_r    <= fold_byte(chk_r, out_data);
          cnt_r    <= cnt_r - 8'd1;
          state_r  <= ST_DATA;
        end

        ST_DATA: begin
          if (hs_s) begin
            if (cnt_r != 8'd0) begin
              tx_valid <= 1'b0;
              rd_req   <= 1'b1;
              state_r  <= ST_FETCH;
            end else begin
              tx_data  <= chk_r;   // already includes the last payload byte
              state_r  <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (hs_s) begin
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= frames_sent + 8'd1;
            state_r     <= ST_IDLE;
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          rd_req   <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_resp_framer.md
# spi_resp_framer

Downstream consumer of the SPI interface's response FIFO: when a response is pending (`have_msg`), it drains the buffered MISO bytes and wraps them into a framed packet on a byte-wide valid/ready stream feeding the host-link transmitter. Each frame is: sync byte, channel ID, payload length, payload, check byte. One frame is emitted per pending burst, so the host receives complete, self-delimited SPI responses.

## Interface
- `SYNC_BYTE`, 8'hA5, first byte of every frame
- `CHAN_ID`, 8'h00, channel identifier byte sent after sync
- `MAX_LEN`, 8'd64, upper bound on payload bytes per frame; larger backlog is split across frames

- `clk`  in  1  clock
- `n_rst`  in  1  reset: asynchronous, active-low
- `have_msg`  in  1  response FIFO non-empty
- `len`  in  8  response FIFO fill level in bytes
- `out_data`  in  8  response FIFO read data; non-show-ahead, valid the cycle after `rd_req`
- `rd_req`  out  1  response FIFO read strobe, one-cycle pulses
- `tx_data`  out  8  frame byte to transmitter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter accepts byte when `tx_valid & tx_ready`
- `busy`  out  1  frame in progress (state != IDLE)
- `frames_sent`  out  8  count of completed frames, wraps 255->0

## Operation
- States: IDLE, SYNC, ID, LEN, FETCH, LOAD, DATA, CHK.
- IDLE: if `have_msg & len != 0` -> latch `cnt = min(len, MAX_LEN)`, clear check accumulator, go to SYNC. If `have_msg & len == 0` (fill level lag), stay in IDLE.
- SYNC/ID/LEN: present `SYNC_BYTE`/`CHAN_ID`/`cnt` with `tx_valid=1`; advance on handshake. LEN -> FETCH.
- FETCH: `rd_req=1` for exactly this cycle, then go to LOAD.
- LOAD: capture `out_data` into `tx_data`, fold it into the check byte, decrement `cnt`, then go to DATA.
- DATA: `tx_valid=1`; on handshake go to FETCH if `cnt != 0`, else go to CHK.
- CHK: present the check byte; on handshake increment `frames_sent` and go to IDLE.
- Check byte (default): 8-bit sum mod 256 of ID, LEN and all payload bytes. SYNC is excluded.
- `tx_data` and `tx_valid` are registered and held stable while `tx_valid & !tx_ready`.
- `rd_req` is never asserted outside FETCH. At most `cnt` reads are issued per frame, so the FIFO is never over-read.
- Backlog > MAX_LEN: the first frame carries MAX_LEN bytes; the remainder forms the next frame from IDLE.
- Input FIFO writes during a frame do not alter the latched `cnt`.

## Timing
- Reset values: `rd_req=0`, `tx_valid=0`, `tx_data=0`, `busy=0`, `frames_sent=0`, state IDLE, `cnt=0`, check accumulator 0.
- Reset asserted mid-frame aborts immediately with no partial check byte. Bytes already read from the FIFO are lost.
- IDLE to first `tx_valid` (SYNC): 1 cycle after the `have_msg & len != 0` sample.
- Per payload byte, with `tx_ready` tied high: FETCH, LOAD, DATA = 3 cycles.
- Frame length with `tx_ready=1`: 3 + 3·N + 1 cycles after leaving IDLE; back-to-back frames add 1 IDLE cycle.
- `tx_ready` low stalls the current state indefinitely with no FIFO reads.

## Configuration
- `SPI_FRAMER_CRC8_EN` defined: the check byte is CRC-8, polynomial 0x07, init 0x00, MSB-first, no final XOR, computed over ID, LEN and payload. It is computed bytewise in LOAD and in the ID/LEN handshakes.
- Not defined: the 8-bit additive sum is used. State sequence and timing are identical in both cases.

## Test plan
- Backlog 0x12, 0x34 (`len=2`), `tx_ready=1`, defaults -> stream A5 00 02 12 34 48. Exactly 2 `rd_req` pulses, `frames_sent=1`. With `SPI_FRAMER_CRC8_EN` the last byte is 0x27.
- Same stimulus with `tx_ready` toggling 1-of-3 cycles -> identical byte stream, `tx_data` stable across stalls, no extra `rd_req`.
- 100-byte backlog, MAX_LEN=64 -> two frames with LEN 0x40 then 0x24. 100 `rd_req` pulses total, `frames_sent=2`.
- `have_msg=1`, `len=0` for 5 cycles, then `len=1` -> no output during the 5 cycles; a frame with LEN 01 follows.
- `n_rst` pulsed low during the DATA state of a 4-byte frame -> all outputs return to reset values asynchronously. The next frame starts cleanly with A5 once the FIFO is non-empty.
- 256 single-byte frames -> `frames_sent` wraps to 0x00.
